// File: rtl/exe_issue_ctrl.sv
// Issue/hazard controller between decode and the execute operand latch.
// Produces operand forwarding selects, sequences multi-cycle MUL ops and tracks EX/WB producers.
module exe_issue_ctrl #(
  parameter logic [4:0]  MUL_OPCODE = 5'b01000,
  parameter int unsigned MC_LAT     = 4,
  parameter logic [4:0]  NOP_OPCODE = 5'b00000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [4:0] dec_opcode,
  input  logic [3:0] dec_dest,
  input  logic [3:0] dec_s1,
  input  logic [3:0] dec_s2,
  output logic       iss_valid,
  output logic [4:0] iss_opcode,
  output logic [3:0] iss_dest,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       mc_start,
  output logic       mc_done,
  output logic       wb_en,
  output logic [3:0] wb_dest
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       iss_valid_q, iss_valid_d;
  logic [4:0] iss_opcode_q, iss_opcode_d;
  logic [3:0] iss_dest_q, iss_dest_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;
  logic       mc_start_q, mc_start_d;
  logic [3:0] mul_dest_q, mul_dest_d;
  logic       ex_en_q, ex_en_d;
  logic [3:0] ex_dest_q, ex_dest_d;
  logic       wb_en_q, wb_en_d;
  logic [3:0] wb_dest_q, wb_dest_d;

  logic accept;
  logic is_mul;
  logic dec_writes;

  // EX producer beats WB producer; r0 is never a producer.
  function automatic logic [1:0] sel_for(input logic [3:0] s,
                                         input logic xe, input logic [3:0] xd,
                                         input logic we, input logic [3:0] wd);
    if (s != 4'd0 && xe && s == xd)      return 2'b01;
    else if (s != 4'd0 && we && s == wd) return 2'b10;
    else                                 return 2'b00;
  endfunction

  assign dec_ready  = (state_q != MC_BUSY) && !reset;
  assign accept     = dec_valid && dec_ready;
  assign is_mul     = (dec_opcode == MUL_OPCODE);
  assign dec_writes = (dec_opcode != NOP_OPCODE) && !is_mul && (dec_dest != 4'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    iss_valid_d  = 1'b0;
    iss_opcode_d = iss_opcode_q;
    iss_dest_d   = iss_dest_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    mc_start_d   = 1'b0;
    mul_dest_d   = mul_dest_q;
    ex_en_d      = 1'b0;
    ex_dest_d    = ex_dest_q;
    wb_en_d      = ex_en_q;
    wb_dest_d    = ex_dest_q;

    case (state_q)
      MC_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // The MUL becomes the EX producer only in the cycle its result is valid.
        if (cnt_q == 4'd1) begin
          state_d   = MC_DONE;
          ex_en_d   = (mul_dest_q != 4'd0);
          ex_dest_d = mul_dest_q;
        end
      end
      MC_DONE: state_d = RUN;
      default: ;
    endcase

    if (flush) begin
      state_d     = RUN;
      cnt_d       = '0;
      iss_valid_d = 1'b0;
      mc_start_d  = 1'b0;
      ex_en_d     = 1'b0;
      wb_en_d     = 1'b0;
    end else if (accept) begin
      iss_valid_d  = 1'b1;
      iss_opcode_d = dec_opcode;
      iss_dest_d   = dec_dest;
      fwd_a_d      = sel_for(dec_s1, ex_en_q, ex_dest_q, wb_en_q, wb_dest_q);
      fwd_b_d      = sel_for(dec_s2, ex_en_q, ex_dest_q, wb_en_q, wb_dest_q);
      if (is_mul) begin
        state_d    = MC_BUSY;
        cnt_d      = 4'(MC_LAT - 1);
        mc_start_d = 1'b1;
        mul_dest_d = dec_dest;
      end else if (dec_writes) begin
        ex_en_d   = 1'b1;
        ex_dest_d = dec_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      iss_valid_q  <= 1'b0;
      iss_opcode_q <= '0;
      iss_dest_q   <= '0;
      fwd_a_q      <= '0;
      fwd_b_q      <= '0;
      mc_start_q   <= 1'b0;
      mul_dest_q   <= '0;
      ex_en_q      <= 1'b0;
      ex_dest_q    <= '0;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iss_valid_q  <= iss_valid_d;
      iss_opcode_q <= iss_opcode_d;
      iss_dest_q   <= iss_dest_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      mc_start_q   <= mc_start_d;
      mul_dest_q   <= mul_dest_d;
      ex_en_q      <= ex_en_d;
      ex_dest_q    <= ex_dest_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_opcode_q;
  assign iss_dest   = iss_dest_q;
  assign fwd_a_sel  = fwd_a_q;
  assign fwd_b_sel  = fwd_b_q;
  assign mc_start   = mc_start_q;
  assign mc_done    = (state_q == MC_DONE);
  assign wb_en      = wb_en_q;
  assign wb_dest    = wb_dest_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Bench for exe_issue_ctrl: cycle-indexed schedule model plus directed hazard/MUL/flush/reset cases.
module tb_exe_issue_ctrl;
  localparam int         MC_LAT = 4;
  localparam logic [4:0] MUL    = 5'b01000;
  localparam logic [4:0] NOP    = 5'b00000;
  localparam int         NC     = 2400;

  logic       clk = 1'b0;
  logic       reset, flush, dec_valid;
  logic [4:0] dec_opcode;
  logic [3:0] dec_dest, dec_s1, dec_s2;
  logic       dec_ready, iss_valid, mc_start, mc_done, wb_en;
  logic [4:0] iss_opcode;
  logic [3:0] iss_dest, wb_dest;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  exe_issue_ctrl #(.MUL_OPCODE(MUL), .MC_LAT(MC_LAT), .NOP_OPCODE(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_dest(dec_dest), .dec_s1(dec_s1), .dec_s2(dec_s2),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_dest(iss_dest),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mc_start(mc_start), .mc_done(mc_done), .wb_en(wb_en), .wb_dest(wb_dest)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: per-cycle expectations, indexed by cycle number (cycle k follows the k-th posedge).
  int exd [NC];   // register written by the EX stage in cycle k, -1 if none
  int wbd [NC];   // register written by WB in cycle k, -1 if none
  bit issv[NC], mcs[NC], dn[NC], rz[NC];
  int eop[NC], edst[NC], efa[NC], efb[NC];
  int busy_lo, busy_hi;

  function automatic int sel(input int s, input int ex, input int wb);
    if (s != 0 && s == ex) return 1;
    if (s != 0 && s == wb) return 2;
    return 0;
  endfunction

  initial begin
    int c;
    bit rdy, acc;
    for (int k = 0; k < NC; k++) begin
      exd[k] = -1; wbd[k] = -1;
      issv[k] = 0; mcs[k] = 0; dn[k] = 0; rz[k] = 0;
      eop[k] = 0; edst[k] = 0; efa[k] = 0; efb[k] = 0;
    end
    rz[1] = 1;
    busy_lo = -1; busy_hi = -1;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (c + 20 < NC) begin
        rdy = !reset && !(c >= busy_lo && c <= busy_hi);
        chk("dec_ready", int'(dec_ready), int'(rdy));
        chk("iss_valid", int'(iss_valid), int'(issv[c]));
        chk("mc_start", int'(mc_start), int'(mcs[c]));
        chk("mc_done", int'(mc_done), int'(dn[c]));
        chk("wb_en", int'(wb_en), int'(wbd[c] >= 0));
        if (wbd[c] >= 0) chk("wb_dest", int'(wb_dest), wbd[c]);
        if (issv[c]) begin
          chk("iss_opcode", int'(iss_opcode), eop[c]);
          chk("iss_dest", int'(iss_dest), edst[c]);
          chk("fwd_a_sel", int'(fwd_a_sel), efa[c]);
          chk("fwd_b_sel", int'(fwd_b_sel), efb[c]);
        end
        if (rz[c]) begin
          chk("rst_opcode", int'(iss_opcode), 0);
          chk("rst_dest", int'(iss_dest), 0);
          chk("rst_fwd_a", int'(fwd_a_sel), 0);
          chk("rst_fwd_b", int'(fwd_b_sel), 0);
          chk("rst_wb_dest", int'(wb_dest), 0);
        end

        acc = dec_valid && rdy;
        if (reset || flush) begin
          for (int k = 1; k <= 16; k++) begin
            exd[c + k] = -1;
            dn[c + k]  = 0;
          end
          wbd[c + 1] = -1;
          busy_lo = -1; busy_hi = -1;
          if (reset) rz[c + 1] = 1;
        end else begin
          wbd[c + 1] = exd[c];
          if (acc) begin
            issv[c + 1] = 1;
            eop[c + 1]  = int'(dec_opcode);
            edst[c + 1] = int'(dec_dest);
            efa[c + 1]  = sel(int'(dec_s1), exd[c], wbd[c]);
            efb[c + 1]  = sel(int'(dec_s2), exd[c], wbd[c]);
            if (dec_opcode == MUL) begin
              mcs[c + 1] = 1;
              busy_lo = c + 1;
              busy_hi = c + MC_LAT - 1;
              dn[c + MC_LAT]  = 1;
              exd[c + MC_LAT] = (dec_dest != 0) ? int'(dec_dest) : -1;
            end else if (dec_opcode != NOP && dec_dest != 0) begin
              exd[c + 1] = int'(dec_dest);
            end
          end
        end
      end
    end
  end

  // Sets the inputs for the current cycle, then advances to just after the next rising edge.
  task automatic cyc(input bit r, input bit f, input bit v,
                     input logic [4:0] op, input logic [3:0] d,
                     input logic [3:0] a, input logic [3:0] b);
    reset = r; flush = f; dec_valid = v;
    dec_opcode = op; dec_dest = d; dec_s1 = a; dec_s2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    logic [4:0] op;
    int r;
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    chk("lit_rst_ready", int'(dec_ready), 0);
    chk("lit_rst_iss_valid", int'(iss_valid), 0);
    chk("lit_rst_wb_en", int'(wb_en), 0);
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);

    // ADD r3 ; SUB r5,r3,r3
    cyc(0, 0, 1, 5'd1, 4'd3, 4'd1, 4'd2);
    cyc(0, 0, 1, 5'd2, 4'd5, 4'd3, 4'd3);
    chk("lit_ex_fwd_a", int'(fwd_a_sel), 1);
    chk("lit_ex_fwd_b", int'(fwd_b_sel), 1);
    // ADD r3 ; NOP ; SUB r5,r3,r1
    cyc(0, 0, 1, 5'd1, 4'd3, 4'd0, 4'd0);
    cyc(0, 0, 1, NOP, 4'd3, 4'd0, 4'd0);
    cyc(0, 0, 1, 5'd2, 4'd5, 4'd3, 4'd1);
    chk("lit_wb_fwd_a", int'(fwd_a_sel), 2);
    chk("lit_wb_fwd_b", int'(fwd_b_sel), 0);
    idle(2);

    // ADD r0 ; SUB r1,r0,r0
    cyc(0, 0, 1, 5'd1, 4'd0, 4'd1, 4'd2);
    cyc(0, 0, 1, 5'd2, 4'd1, 4'd0, 4'd0);
    chk("lit_r0_fwd_a", int'(fwd_a_sel), 0);
    chk("lit_r0_fwd_b", int'(fwd_b_sel), 0);
    chk("lit_r0_wb_en", int'(wb_en), 0);
    idle(2);

    // MUL r7, decode keeps offering ADD while busy, then ADD r2,r7,r1 at mc_done
    cyc(0, 0, 1, MUL, 4'd7, 4'd1, 4'd2);
    chk("lit_mul_start", int'(mc_start), 1);
    chk("lit_mul_busy1", int'(dec_ready), 0);
    cyc(0, 0, 1, 5'd1, 4'd4, 4'd0, 4'd0);
    chk("lit_mul_busy2", int'(dec_ready), 0);
    cyc(0, 0, 1, 5'd1, 4'd4, 4'd0, 4'd0);
    chk("lit_mul_busy3", int'(dec_ready), 0);
    cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    chk("lit_mul_done", int'(mc_done), 1);
    chk("lit_mul_ready", int'(dec_ready), 1);
    cyc(0, 0, 1, 5'd1, 4'd2, 4'd7, 4'd1);
    chk("lit_mul_fwd_a", int'(fwd_a_sel), 1);
    chk("lit_mul_wb_en", int'(wb_en), 1);
    chk("lit_mul_wb_dest", int'(wb_dest), 7);
    idle(2);

    // MUL r7 flushed at T+2
    cyc(0, 0, 1, MUL, 4'd7, 4'd1, 4'd2);
    cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    cyc(0, 1, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    chk("lit_flush_ready", int'(dec_ready), 1);
    idle(1);
    chk("lit_flush_no_done", int'(mc_done), 0);
    idle(1);
    chk("lit_flush_no_wb", int'(wb_en), 0);
    idle(2);

    // MUL r7 interrupted by reset at T+2
    cyc(0, 0, 1, MUL, 4'd7, 4'd1, 4'd2);
    cyc(0, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 5'd0, 4'd0, 4'd0, 4'd0);
    chk("lit_rstmul_iss_valid", int'(iss_valid), 0);
    chk("lit_rstmul_opcode", int'(iss_opcode), 0);
    chk("lit_rstmul_mc_done", int'(mc_done), 0);
    idle(1);
    chk("lit_rstmul_no_done", int'(mc_done), 0);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) op = MUL;
      else if (r < 40) op = NOP;
      else begin
        op = 5'($urandom_range(1, 30));
        if (op >= 5'd8) op = op + 5'd1;
      end
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 7, op,
          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end
    idle(MC_LAT + 2);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
